// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: sequencer states and datapath widths.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned INSTR_W  = 15;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 7'h7F;

  // Encoding is architecturally visible on the state port; 3'd7 is unused.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Gates the control decoder's
// write requests so each architectural write happens in exactly one cycle,
// and adds run/step/halt control plus a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          MEM_WAIT    = 1,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                dec_la,
  input  logic                dec_lb,
  input  logic                dec_lp,
  input  logic                dec_mem,
  input  logic                dec_mem_we,
  input  logic                dec_flags,
  input  logic                dec_illegal,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                LA,
  output logic                LB,
  output logic                mem_we,
  output logic                status_we,
  output logic [2:0]          state,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [15:0]         instr_count
);

  localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t           state_q;
  logic             step_mode;
  logic [CNT_W-1:0] mem_cnt;
  logic             err_q;

  // Sequencer state, MEM wait counter, retire counter and halt cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_mode   <= 1'b0;
      mem_cnt     <= '0;
      instr_count <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: begin
          if (opcode == HALT_OPCODE) begin
            state_q <= ST_HALT;
            err_q   <= 1'b0;
          end else if (dec_illegal) begin
            state_q <= ST_HALT;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec_mem) begin
            state_q <= ST_MEM;
            mem_cnt <= CNT_W'(MEM_WAIT - 1);
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_cnt == '0) state_q <= ST_WB;
          else               mem_cnt <= mem_cnt - 1'b1;
        end
        ST_WB: begin
          instr_count <= instr_count + 16'd1;
          state_q     <= (step_mode || !run) ? ST_IDLE : ST_FETCH;
        end
        ST_HALT:   state_q <= ST_HALT;
        // IDLE, and the unused encoding which behaves as IDLE.
        default: begin
          if (run) begin
            state_q   <= ST_FETCH;
            step_mode <= 1'b0;
          end else if (step) begin
            state_q   <= ST_FETCH;
            step_mode <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Write strobes decoded from the registered state, gated by the decoder requests.
  always_comb begin
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    LA        = 1'b0;
    LB        = 1'b0;
    mem_we    = 1'b0;
    status_we = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        ir_load = 1'b1;
        busy    = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        status_we = dec_flags;
        busy      = 1'b1;
      end
      ST_MEM: begin
        mem_we = dec_mem_we && (mem_cnt == '0);
        busy   = 1'b1;
      end
      ST_WB: begin
        LA      = dec_la;
        LB      = dec_lb;
        pc_load = dec_lp;
        pc_inc  = !dec_lp;
        busy    = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer. Each instruction is expanded
// into its expected phase sequence and per-phase strobes from the sequencing rules.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int unsigned MW = 3;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic [6:0]  opcode;
  logic        dec_la, dec_lb, dec_lp, dec_mem, dec_mem_we, dec_flags, dec_illegal;
  logic        ir_load, pc_inc, pc_load, LA, LB, mem_we, status_we;
  logic [2:0]  state;
  logic        busy, halted, err;
  logic [15:0] instr_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count = '0;
  bit          ei;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_WAIT(MW), .HALT_OPCODE(7'h7F)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .dec_la(dec_la), .dec_lb(dec_lb), .dec_lp(dec_lp), .dec_mem(dec_mem),
    .dec_mem_we(dec_mem_we), .dec_flags(dec_flags), .dec_illegal(dec_illegal),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .LA(LA), .LB(LB),
    .mem_we(mem_we), .status_we(status_we), .state(state), .busy(busy),
    .halted(halted), .err(err), .instr_count(instr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {ir_load, pc_inc, pc_load, LA, LB, mem_we, status_we, busy, halted, err}
  function automatic logic [9:0] obs();
    obs = {ir_load, pc_inc, pc_load, LA, LB, mem_we, status_we, busy, halted, err};
  endfunction

  function automatic logic [9:0] vec(input bit ir, pi, pl, la, lb, mw, sw, bz, hl, er);
    vec = {ir, pi, pl, la, lb, mw, sw, bz, hl, er};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cycle(input string tag, input int st, input logic [9:0] v);
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".out"}, 32'(obs()), 32'(v));
    check_eq({tag, ".count"}, 32'(instr_count), 32'(exp_count));
  endtask

  // Optional disturbance while an instruction is in flight: a stray step pulse
  // in step mode, or dropping run in run mode when the program should stop.
  task automatic poke(input int stage, input int pick, input int mode, input bit stay);
    if (stage == pick) begin
      if (mode == 1) step = 1'b1;
      else if (!stay) run = 1'b0;
    end
  endtask

  // mode: 0 = start from IDLE with run, 1 = start from IDLE with step,
  //       2 = continue from the WB of a previous run-mode instruction.
  task automatic do_instr(input bit [6:0] op, input bit la, lb, lp, mem, we, fl, ill,
                          input int mode, input bit stay, input int pick,
                          output bit ended_idle);
    opcode = op; dec_la = la; dec_lb = lb; dec_lp = lp;
    dec_mem = mem; dec_mem_we = we; dec_flags = fl; dec_illegal = ill;
    if (mode == 0) run = 1'b1;
    if (mode == 1) begin run = 1'b0; step = 1'b1; end
    tick(); step = 1'b0;
    expect_cycle("fetch", 1, vec(1,0,0,0,0,0,0,1,0,0));
    poke(1, pick, mode, stay);
    tick(); step = 1'b0;
    expect_cycle("decode", 2, vec(0,0,0,0,0,0,0,1,0,0));
    if (op == 7'h7F || ill) begin
      tick();
      expect_cycle("halt", 6, vec(0,0,0,0,0,0,0,0,1, (op != 7'h7F)));
      ended_idle = 1'b0;
      return;
    end
    poke(2, pick, mode, stay);
    tick(); step = 1'b0;
    expect_cycle("exec", 3, vec(0,0,0,0,0,0,fl,1,0,0));
    poke(3, pick, mode, stay);
    if (mem) begin
      for (int i = 0; i < int'(MW); i++) begin
        tick(); step = 1'b0;
        expect_cycle("mem", 4, vec(0,0,0,0,0, (we && i == int'(MW) - 1), 0,1,0,0));
      end
    end
    tick(); step = 1'b0;
    expect_cycle("wb", 5, vec(0, !lp, lp, la, lb, 0,0,1,0,0));
    exp_count = exp_count + 16'd1;
    ended_idle = (mode == 1) || !stay;
    if (mode != 1 && !stay) run = 1'b0;
    if (ended_idle) begin
      tick();
      expect_cycle("idle", 0, vec(0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  mode;
    bit  stay;
    rst = 1'b1; run = 1'b0; step = 1'b0; opcode = '0;
    dec_la = 0; dec_lb = 0; dec_lp = 0; dec_mem = 0; dec_mem_we = 0; dec_flags = 0; dec_illegal = 0;
    repeat (2) @(negedge clk);
    expect_cycle("reset", 0, '0);
    rst = 1'b0;
    tick();
    expect_cycle("idle0", 0, '0);

    // Three back-to-back ALU instructions under continuous run.
    do_instr(7'h10, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, ei);
    do_instr(7'h11, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, ei);
    do_instr(7'h12, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0, ei);
    // Store with MEM_WAIT cycles of memory phase.
    do_instr(7'h20, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, ei);
    // Single step with a stray step pulse during EXEC.
    do_instr(7'h21, 1, 0, 0, 0, 0, 1, 0, 1, 0, 3, ei);
    // Jump with run dropped during DECODE.
    do_instr(7'h30, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, ei);

    // Random instruction stream.
    ei = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit [6:0] op;
      op = 7'($urandom_range(0, 126));
      mode = ei ? int'($urandom_range(0, 1)) : 2;
      stay = (n == 39) ? 1'b0 : 1'($urandom);
      do_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'b0, mode, stay, int'($urandom_range(0, 3)), ei);
    end

    // Reset in the middle of EXEC aborts with every output cleared immediately.
    opcode = 7'h05; dec_la = 1; dec_lb = 1; dec_lp = 0; dec_mem = 0; dec_flags = 1;
    run = 1'b1;
    tick(); expect_cycle("pre_fetch", 1, vec(1,0,0,0,0,0,0,1,0,0));
    tick(); expect_cycle("pre_decode", 2, vec(0,0,0,0,0,0,0,1,0,0));
    tick(); expect_cycle("pre_exec", 3, vec(0,0,0,0,0,0,1,1,0,0));
    #1 rst = 1'b1;
    exp_count = '0;
    #1 expect_cycle("rst_exec", 0, '0);
    @(negedge clk);
    expect_cycle("rst_hold", 0, '0);
    run = 1'b0; rst = 1'b0;
    tick(); expect_cycle("rst_idle", 0, '0);

    // Retire one, then HALT opcode: halts without retiring, err clear.
    do_instr(7'h01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ei);
    do_instr(7'h7F, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, ei);
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); step = 1'b1;
      tick();
      expect_cycle("halt_hold", 6, vec(0,0,0,0,0,0,0,0,1,0));
    end
    step = 1'b0; run = 1'b0;
    rst = 1'b1; exp_count = '0;
    @(negedge clk); rst = 1'b0;
    tick(); expect_cycle("idle_a", 0, '0);

    // Illegal opcode halts with err set; HALT opcode wins over illegal.
    do_instr(7'h33, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ei);
    for (int i = 0; i < 3; i++) begin
      run = 1'b1; step = 1'($urandom);
      tick();
      expect_cycle("illegal_hold", 6, vec(0,0,0,0,0,0,0,0,1,1));
    end
    step = 1'b0; run = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tick(); expect_cycle("idle_b", 0, '0);
    do_instr(7'h7F, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ei);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the 8-bit accumulator CPU (PC, 15-bit instruction memory, regA/regB, ALU, status register, data memory). It replaces free-running single-cycle execution with a FETCH/DECODE/EXEC/MEM/WB state machine. It gates every architectural write strobe produced by the combinational control decoder, and adds run/single-step/halt control plus a retired-instruction counter.

## Interface
- MEM_WAIT, default 1: cycles spent in MEM per memory instruction (≥1).
- HALT_OPCODE, default 7'h7F: opcode that stops the CPU.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level: 1 = execute continuously; 0 = stop at next instruction boundary.
- step  in  1  one-cycle pulse: execute exactly one instruction from IDLE.
- opcode  in  7  instruction register opcode field (im_out[14:8]).
- dec_la, dec_lb  in  1  decoder load requests for regA/regB.
- dec_lp  in  1  decoder jump-taken (PC load from K).
- dec_mem  in  1  instruction accesses data memory.
- dec_mem_we  in  1  instruction writes data memory.
- dec_flags  in  1  instruction updates status flags.
- dec_illegal  in  1  opcode not implemented.
- ir_load  out  1  latch instruction memory output into IR.
- pc_inc, pc_load  out  1  PC advance / PC := K (mutually exclusive).
- LA, LB  out  1  gated register loads.
- mem_we  out  1  gated data-memory write.
- status_we  out  1  gated status-register load.
- state  out  3  current state encoding.
- busy  out  1  state ∉ {IDLE, HALT}.
- halted, err  out  1  HALT reached; err = halt caused by illegal opcode.
- instr_count  out  16  retired instructions, wraps at 16'hFFFF→0.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unreachable, decodes to IDLE.
- IDLE: run=1 → FETCH, step_mode=0. Otherwise step=1 → FETCH, step_mode=1. run has priority over step.
- FETCH: ir_load=1 for exactly one cycle → DECODE.
- DECODE: opcode==HALT_OPCODE → HALT, err=0. Otherwise dec_illegal → HALT, err=1. Otherwise → EXEC.
- EXEC: status_we=dec_flags. Next state is MEM if dec_mem, else WB.
- MEM: down-counter loaded with MEM_WAIT-1 on entry. mem_we=dec_mem_we only in the final MEM cycle. → WB when counter==0.
- WB: LA=dec_la, LB=dec_lb. Exactly one of pc_load (dec_lp) or pc_inc (!dec_lp). instr_count+1. Then: step_mode or run=0 → IDLE, else FETCH.
- HALT: all strobes 0, halted=1. Exits only via rst. run and step are ignored.
- Outside the states listed above, every strobe output is 0. Strobes are registered-state decodes (Moore), never combinational from run/step.
- step pulses outside IDLE are ignored (not queued). run deassertion mid-instruction completes the instruction.
- HALT instruction does not retire: no PC change, instr_count unchanged.

## Timing
- Reset (async assert, sync release): state=IDLE, step_mode=0, MEM counter=0, instr_count=0. All strobes, busy, halted, err = 0.
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB). Memory instruction: 4+MEM_WAIT cycles.
- run sampled in IDLE → FETCH next cycle. Continuous run: WB is followed directly by FETCH, with no IDLE bubble.
- rst mid-instruction: aborts immediately. No strobe asserts after reset asserts. A partially executed instruction leaves no architectural write except those already committed in earlier cycles (status in EXEC).
- instr_count wrap: 16'hFFFF + 1 → 16'h0000, no flag.

## Structure
- Package cpu_pkg: state enum (3-bit), HALT_OPCODE default, opcode width 7, data width 8, instruction width 15. Shared with the control decoder.
- Single module. The MEM wait counter is inline (not a sub-module). The sequencer is instantiated in computer alongside the control unit, ANDing its strobes.

## Test plan
- Reset mid-EXEC with run=1: all outputs 0, state=0, instr_count=0 within the same cycle as rst assertion.
- run=1, 3 ALU instructions (dec_mem=0): ir_load pulses at cycles 1,5,9. pc_inc pulses at 4,8,12. instr_count=3. busy stays 1.
- MEM_WAIT=3, store instruction (dec_mem=1, dec_mem_we=1): MEM lasts 3 cycles, mem_we high only in the 3rd. Total 7 cycles.
- step pulse in IDLE with run=0: exactly one instruction retires, then state=IDLE. Second step pulse during EXEC is ignored; instr_count=1.
- Jump (dec_lp=1): pc_load=1 and pc_inc=0 in WB. run dropped during DECODE → instruction completes, then IDLE.
- opcode=7'h7F → HALT, halted=1, err=0, instr_count unchanged. dec_illegal=1 → HALT with err=1. run/step then have no effect until rst.
